// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared widths, ALU select codes and issue FSM states
// Purpose: common definitions for the ALU issue stage and its register file.
// Contents: DATA_W_DEF, SEL_W, SEL_* select codes, issue_state_e.
package alu_issue_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W      = 4;

  // Select codes understood by alu_module; mode chooses the arithmetic or logic family.
  localparam logic [SEL_W-1:0] SEL_ADD   = 4'h0;
  localparam logic [SEL_W-1:0] SEL_SUB   = 4'h1;
  localparam logic [SEL_W-1:0] SEL_AND   = 4'h2;
  localparam logic [SEL_W-1:0] SEL_OR    = 4'h3;
  localparam logic [SEL_W-1:0] SEL_XOR   = 4'h4;
  localparam logic [SEL_W-1:0] SEL_PASSA = 4'h5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - load/command/ALU/response bundle of the issue stage
// Purpose: groups every handshake and ALU-facing signal of alu_issue_ctrl.
// Modports: master = environment (loads, commands, ALU results, rsp_ready),
//           slave  = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  import alu_issue_ctrl_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [SEL_W-1:0]  cmd_sel;
  logic              cmd_use_carry;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [ADDR_W-1:0] cmd_rd;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_mode;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;
  logic              alu_cmp;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_cmp;

  modport master (
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output cmd_valid, cmd_mode, cmd_sel, cmd_use_carry, cmd_ra, cmd_rb, cmd_rd,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel, alu_mode, alu_cin,
    output alu_res, alu_cout, alu_cmp,
    input  rsp_valid, rsp_data, rsp_carry, rsp_cmp,
    output rsp_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  cmd_valid, cmd_mode, cmd_sel, cmd_use_carry, cmd_ra, cmd_rb, cmd_rd,
    output cmd_ready,
    output alu_a, alu_b, alu_sel, alu_mode, alu_cin,
    input  alu_res, alu_cout, alu_cmp,
    output rsp_valid, rsp_data, rsp_carry, rsp_cmp,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// rtl/alu_issue_ctrl_regfile.sv - operand register file, 1 write / 2 async read ports
// Purpose: NUM_REGS x DATA_W storage cleared by reset.
// Ports: clk, rst (async, active-high); we/waddr/wdata write port;
//        raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module alu_issue_ctrl_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue stage driving the combinational ALU from a small register file
// Purpose: accepts preloads and one ALU command at a time, registers operands to the ALU,
//          captures result/flags, writes the result back and returns a response.
// Ports: clk, rst (async, active-high); bus (alu_issue_ctrl_if.slave) carrying the
//        ld_*, cmd_*, alu_* and rsp_* groups.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_ctrl_if.slave      bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  issue_state_e      state;

  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic              alu_mode_q;
  logic              alu_cin_q;
  logic [ADDR_W-1:0] rd_q;

  logic [DATA_W-1:0] res_q;
  logic              cout_q;
  logic              cmp_q;

  logic              carry_flag;
  logic              cmp_flag;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_carry_q;
  logic              rsp_cmp_q;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  // The single write port is shared: preloads in IDLE, result write-back in WB.
  // The two states are exclusive, so no arbitration is needed.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.ld_addr;
    rf_wdata = bus.ld_data;
    if (state == WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = res_q;
    end else if (state == IDLE && bus.ld_valid) begin
      rf_we    = 1'b1;
    end
  end

  alu_issue_ctrl_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (bus.cmd_ra),
    .rdata_a (rf_rdata_a),
    .raddr_b (bus.cmd_rb),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_mode_q  <= 1'b0;
      alu_cin_q   <= 1'b0;
      rd_q        <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      cmp_q       <= 1'b0;
      carry_flag  <= 1'b0;
      cmp_flag    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_cmp_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A pending load blocks command acceptance for this cycle.
          if (!bus.ld_valid && bus.cmd_valid) begin
            alu_a_q    <= rf_rdata_a;
            alu_b_q    <= rf_rdata_b;
            alu_sel_q  <= bus.cmd_sel;
            alu_mode_q <= bus.cmd_mode;
            alu_cin_q  <= bus.cmd_use_carry & carry_flag;
            rd_q       <= bus.cmd_rd;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= bus.alu_res;
          cout_q <= bus.alu_cout;
          cmp_q  <= bus.alu_cmp;
          state  <= WB;
        end
        WB: begin
          // Logic ops leave both flags as they were so an add/sub chain survives them.
          if (!alu_mode_q) begin
            carry_flag <= cout_q;
            cmp_flag   <= cmp_q;
          end
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= res_q;
          rsp_carry_q <= alu_mode_q ? carry_flag : cout_q;
          rsp_cmp_q   <= alu_mode_q ? cmp_flag : cmp_q;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready  = (state == IDLE);
  assign bus.cmd_ready = (state == IDLE) && !bus.ld_valid;

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_sel  = alu_sel_q;
  assign bus.alu_mode = alu_mode_q;
  assign bus.alu_cin  = alu_cin_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_cmp   = rsp_cmp_q;

endmodule
